wb_regfile_stage: RTL and testbench

- Consumer end of the MEM-to-WB pipeline interface.
- Takes the registered op_type, read_data, alu_result and write_reg_address from the MEM/WB register and selects the writeback value.
- Commits that value into a 32x32 general-purpose register file and serves the ID stage's two read ports with same-cycle write-through bypass.
- Exports the writeback bus for EX forwarding and keeps a retired-instruction counter.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/regfile_2r1w.sv | 50 +++++
 rtl/wb_regfile_stage.sv | 67 ++++++
 tb/tb_wb_regfile_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: op classes, width defaults and the
// destination-write predicate used by WB, hazard and forwarding logic.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int OP_W       = 4;

    localparam logic [OP_W-1:0] OP_NOP    = 4'd0;
    localparam logic [OP_W-1:0] OP_RTYPE  = 4'd1;
    localparam logic [OP_W-1:0] OP_IALU   = 4'd2;
    localparam logic [OP_W-1:0] OP_LW     = 4'd3;
    localparam logic [OP_W-1:0] OP_SW     = 4'd4;
    localparam logic [OP_W-1:0] OP_BRANCH = 4'd5;
    localparam logic [OP_W-1:0] OP_J      = 4'd6;
    localparam logic [OP_W-1:0] OP_JAL    = 4'd7;
    localparam logic [OP_W-1:0] OP_LUI    = 4'd8;

    // Op classes that produce a register result; reserved codes fall out as no-write.
    function automatic logic writes_reg(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_IALU, OP_LW, OP_JAL, OP_LUI: writes_reg = 1'b1;
            default:                                  writes_reg = 1'b0;
        endcase
    endfunction

    // Any defined non-NOP op counts as retired when it reaches WB.
    function automatic logic is_retiring(input logic [OP_W-1:0] op);
        is_retiring = (op >= OP_RTYPE) && (op <= OP_LUI);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register array with r0 hardwired to zero and write-through
// bypass so a value being written is visible on the read ports the same cycle.
module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] raddr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (raddr == '0)
            read_port = '0;
        else if (we && (waddr == raddr))
            read_port = wdata;
        else
            read_port = stored;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = read_port(raddr_a_i, regs_q[raddr_a_i], we_i, waddr_i, wdata_i);
        rdata_b_o = read_port(raddr_b_i, regs_q[raddr_b_i], we_i, waddr_i, wdata_i);
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects the WB value from the MEM/WB register, commits it to
// the register file, exports the WB bus for forwarding and counts retired ops.
module wb_regfile_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   op_type,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] write_reg_address,
    input  logic [ADDR_W-1:0] rs_address,
    input  logic [ADDR_W-1:0] rt_address,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              wb_write_en,
    output logic [ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retired_count
);

    logic [31:0] retired_q;
    logic [31:0] retired_d;

    // Gating on reset keeps both the array write and the bypass path quiet.
    always_comb begin
        wb_reg      = write_reg_address;
        wb_data     = (op_type == OP_LW) ? read_data : alu_result;
        wb_write_en = writes_reg(op_type) && (write_reg_address != '0) && !reset;
    end

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (wb_write_en),
        .waddr_i   (wb_reg),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_address),
        .raddr_b_i (rt_address),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

    always_comb begin
        retired_d = retired_q;
        if (is_retiring(op_type))
            retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            retired_q <= '0;
        else
            retired_q <= retired_d;
    end

    assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Randomized self-checking bench for wb_regfile_stage against an array-based
// architectural model of the register file and retire counter.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op_type;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  write_reg_address;
    logic [4:0]  rs_address;
    logic [4:0]  rt_address;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_write_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    wb_regfile_stage dut (
        .clk               (clk),
        .reset             (reset),
        .op_type           (op_type),
        .read_data         (read_data),
        .alu_result        (alu_result),
        .write_reg_address (write_reg_address),
        .rs_address        (rs_address),
        .rt_address        (rt_address),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .wb_write_en       (wb_write_en),
        .wb_reg            (wb_reg),
        .wb_data           (wb_data),
        .retired_count     (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Ops whose result lands in a destination register, as listed in the ISA.
    function automatic bit op_writes(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd7) || (op == 4'd8);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return model_regs[a];
    endfunction

    // Apply inputs, then compare every output against the model at the falling edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rst);
        bit          exp_we;
        logic [31:0] exp_wd;
        op_type = op; read_data = rd; alu_result = alu;
        write_reg_address = wa; rs_address = rs; rt_address = rt; reset = rst;
        @(negedge clk);
        exp_we = op_writes(op) && (wa != 5'd0) && !rst;
        exp_wd = (op == 4'd3) ? rd : alu;
        check("wb_write_en", {31'd0, wb_write_en}, {31'd0, exp_we});
        check("wb_reg", {27'd0, wb_reg}, {27'd0, wa});
        check("wb_data", wb_data, exp_wd);
        check("rs_data", rs_data, model_read(rs, exp_we, wa, exp_wd));
        check("rt_data", rt_data, model_read(rt, exp_we, wa, exp_wd));
        check("retired_count", retired_count, model_count);
    endtask

    // Clock the DUT and advance the model by the architectural rules.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_count = 32'd0;
        end else begin
            if (op_writes(op_type) && write_reg_address != 5'd0)
                model_regs[write_reg_address] = (op_type == 4'd3) ? read_data : alu_result;
            if (op_type >= 4'd1 && op_type <= 4'd8)
                model_count = model_count + 32'd1;
        end
        #1;
    endtask

    initial begin
        logic [4:0] pool [4];
        logic [4:0] wa, rs, rt;

        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;
        op_type = 4'd0; read_data = '0; alu_result = '0;
        write_reg_address = '0; rs_address = '0; rt_address = '0; reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        // Reset then read
        drive(4'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31, 1'b1);
        check("rst_rs5", rs_data, 32'd0);
        check("rst_rt31", rt_data, 32'd0);
        check("rst_count", retired_count, 32'd0);
        tick();

        // LW writeback with bypass, then from the array
        drive(4'd3, 32'hDEADBEEF, 32'h1234, 5'd8, 5'd8, 5'd0, 1'b0);
        check("lw_bypass", rs_data, 32'hDEADBEEF);
        tick();
        drive(4'd0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd8, 1'b0);
        check("lw_array", rs_data, 32'hDEADBEEF);
        check("lw_count", retired_count, 32'd1);
        tick();

        // r0 protection
        drive(4'd1, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1'b0);
        check("r0_we", {31'd0, wb_write_en}, 32'd0);
        check("r0_byp", rs_data, 32'd0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("r0_later", rt_data, 32'd0);
        tick();

        // SW and BRANCH retire without writing
        drive(4'd4, 32'd0, 32'h55, 5'd9, 5'd9, 5'd9, 1'b0);
        check("sw_we", {31'd0, wb_write_en}, 32'd0);
        tick();
        drive(4'd5, 32'd0, 32'h55, 5'd9, 5'd9, 5'd9, 1'b0);
        check("br_r9", rs_data, 32'd0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd8, 1'b0);
        check("nw_r9", rs_data, 32'd0);
        check("nw_count", retired_count, 32'd4);
        tick();

        // Back-to-back writes to r3
        drive(4'd1, 32'd0, 32'h11, 5'd3, 5'd3, 5'd3, 1'b0);
        check("b2b_1a", rs_data, 32'h11);
        check("b2b_1b", rt_data, 32'h11);
        tick();
        drive(4'd2, 32'd0, 32'h22, 5'd3, 5'd3, 5'd3, 1'b0);
        check("b2b_2a", rs_data, 32'h22);
        check("b2b_2b", rt_data, 32'h22);
        tick();
        drive(4'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3, 1'b0);
        check("b2b_3", rs_data, 32'h22);
        tick();

        // Reset mid-stream discards a same-cycle JAL
        drive(4'd1, 32'd0, 32'hA5A5A5A5, 5'd4, 5'd4, 5'd0, 1'b0);
        tick();
        drive(4'd7, 32'd0, 32'h400, 5'd31, 5'd31, 5'd4, 1'b1);
        check("mid_rst_we", {31'd0, wb_write_en}, 32'd0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 5'd0, 5'd31, 5'd4, 1'b0);
        check("mid_r31", rs_data, 32'd0);
        check("mid_r4", rt_data, 32'd0);
        check("mid_count", retired_count, 32'd0);
        tick();

        // Randomized traffic over a small hot address pool to force collisions
        for (int i = 0; i < 4; i++) pool[i] = 5'($urandom_range(0, 31));
        for (int n = 0; n < 400; n++) begin
            wa = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 2) == 0) ? wa : pool[$urandom_range(0, 3)];
            rt = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(4'($urandom_range(0, 15)), $urandom, $urandom, wa, rs, rt,
                  ($urandom_range(0, 39) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
